// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // A zero-wait memory still needs a one-bit counter to hold the constant 0.
  function automatic int unsigned timer_width(input int unsigned wait_states);
    return (wait_states == 0) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// rtl/dmem_wait_timer.sv - loadable down-counter that times memory wait states
module dmem_wait_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one single-port data memory between the pipeline and a debug port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wd,
  output logic [DW-1:0] p_rd,
  output logic          p_ack,
  output logic          p_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic [DW-1:0] d_rd,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned CW = timer_width(WAIT_STATES);

  arb_state_t    state;
  arb_owner_t    owner;
  arb_owner_t    last;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] p_rd_hold;
  logic [DW-1:0] d_rd_hold;
  logic          grant_p;
  logic          grant_d;
  logic          grant;
  logic          timer_zero;

  // On contention the port that was not served last wins, so neither can starve.
  always_comb begin
    grant_p = 1'b0;
    grant_d = 1'b0;
    if (state == ARB_IDLE) begin
      if (p_req && d_req) begin
        grant_p = (last == OWN_D);
        grant_d = (last == OWN_P);
      end else begin
        grant_p = p_req;
        grant_d = d_req;
      end
    end
  end

  assign grant = grant_p | grant_d;

  dmem_wait_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (CW'(WAIT_STATES)),
    .dec      (state == ARB_ACCESS),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      owner     <= OWN_P;
      last      <= OWN_D;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      rdata_q   <= '0;
      p_rd_hold <= '0;
      d_rd_hold <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            owner  <= grant_d ? OWN_D : OWN_P;
            we_q   <= grant_d ? d_we : p_we;
            addr_q <= grant_d ? d_addr : p_addr;
            wd_q   <= grant_d ? d_wd : p_wd;
            state  <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (timer_zero) begin
            rdata_q <= mem_rd;
            state   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          if (owner == OWN_P) begin
            p_rd_hold <= rdata_q;
          end else begin
            d_rd_hold <= rdata_q;
          end
          last  <= owner;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign p_ack   = (state == ARB_DONE) && (owner == OWN_P);
  assign d_ack   = (state == ARB_DONE) && (owner == OWN_D);
  assign p_rd    = p_ack ? rdata_q : p_rd_hold;
  assign d_rd    = d_ack ? rdata_q : d_rd_hold;
  assign p_stall = p_req & ~p_ack;

  // The write strobe fires only in the final access cycle; reset masks it so a cut store never lands.
  assign mem_en  = (state == ARB_ACCESS);
  assign mem_we  = mem_en & timer_zero & we_q & ~reset;
  assign mem_adr = addr_q;
  assign mem_wd  = wd_q;

endmodule
